// File: rtl/upc_tag_tx.sv
// upc_tag_tx: serial transmitter for {U,P,C}+mark item tags.
// Each accepted tag is sent LSB first on an idle-high line as
// start(0), data bits, even parity, stop(1), each held BIT_CYCLES clocks.
// Optional build macro UPC_TX_CLASS_EN appends two class bits
// (discounted, stolen) to the data field.
module upc_tag_tx #(
   parameter int unsigned BIT_CYCLES = 4,
   localparam int unsigned CNT_W = $clog2(BIT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tag_valid,
   input  logic [2:0] tag_upc,
   input  logic       tag_mark,
   output logic       tag_ready,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

`ifdef UPC_TX_CLASS_EN
   localparam int unsigned DATA_W = 6;
`else
   localparam int unsigned DATA_W = 4;
`endif
   localparam int unsigned IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t              state, nxt_state;
   logic [CNT_W-1:0]    cnt, nxt_cnt;
   logic [DATA_W-1:0]   sreg, nxt_sreg;
   logic [IDX_W-1:0]    bidx, nxt_bidx;
   logic                par, nxt_par;
   logic                nxt_tx, nxt_busy, nxt_ready, nxt_done;
   logic                bit_end;
   logic [DATA_W-1:0]   tag_word;

   // Data field in transmit order: bit0 goes out first.
`ifdef UPC_TX_CLASS_EN
   logic disc, stolen;
   always_comb begin
      disc     = tag_upc[1] | (tag_upc[2] & tag_upc[0]);
      stolen   = (tag_upc[2] | ~tag_upc[0]) & ~tag_upc[1] & ~tag_mark;
      tag_word = {stolen, disc, tag_upc, tag_mark};
   end
`else
   always_comb begin
      tag_word = {tag_upc, tag_mark};
   end
`endif

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         sreg       <= '0;
         bidx       <= '0;
         par        <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         tag_ready  <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         sreg       <= nxt_sreg;
         bidx       <= nxt_bidx;
         par        <= nxt_par;
         tx         <= nxt_tx;
         busy       <= nxt_busy;
         tag_ready  <= nxt_ready;
         frame_done <= nxt_done;
      end
   end

   // Next-state, bit timing, shifting and next output values.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_sreg  = sreg;
      nxt_bidx  = bidx;
      nxt_par   = par;
      nxt_done  = 1'b0;
      nxt_tx    = 1'b1;
      bit_end   = (cnt == CNT_LAST);

      // Bit-period counter free-runs outside IDLE, wrapping at each bit boundary.
      if (state != IDLE) begin
         nxt_cnt = bit_end ? '0 : cnt + CNT_W'(1);
      end

      case (state)
         IDLE: begin
            nxt_cnt = '0;
            if (tag_valid) begin
               nxt_sreg  = tag_word;
               nxt_par   = ^tag_word;
               nxt_bidx  = '0;
               nxt_state = START;
            end
         end
         START: begin
            if (bit_end) nxt_state = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bidx == LAST_IDX) begin
                  nxt_state = PARITY;
               end else begin
                  nxt_sreg = {1'b0, sreg[DATA_W-1:1]};
                  nxt_bidx = bidx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) nxt_state = STOP;
         end
         STOP: begin
            if (bit_end) begin
               nxt_state = IDLE;
               nxt_done  = 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase

      // Line level for the cycle following this edge.
      case (nxt_state)
         IDLE:    nxt_tx = 1'b1;
         START:   nxt_tx = 1'b0;
         DATA:    nxt_tx = nxt_sreg[0];
         PARITY:  nxt_tx = nxt_par;
         STOP:    nxt_tx = 1'b1;
         default: nxt_tx = 1'b1;
      endcase

      nxt_busy  = (nxt_state != IDLE);
      nxt_ready = (nxt_state == IDLE);
   end

endmodule

// File: tb/tb_upc_tag_tx.sv
// Bench for upc_tag_tx: two instances (BIT_CYCLES=4 and 1) checked every
// cycle against a frame-list model, plus literal frame expectations.
module tb_upc_tag_tx;

`ifdef UPC_TX_CLASS_EN
   localparam int NB = 9;
   localparam logic [8:0] F_101 = 9'h174;
   localparam logic [8:0] F_111 = 9'h1BE;
   localparam logic [8:0] F_A   = 9'h1AA;
   localparam logic [8:0] F_B   = 9'h1C0;
`else
   localparam int NB = 7;
   localparam logic [8:0] F_101 = 9'h054;
   localparam logic [8:0] F_111 = 9'h05E;
   localparam logic [8:0] F_A   = 9'h04A;
   localparam logic [8:0] F_B   = 9'h040;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] v_i;
   logic [2:0] upc_i [2];
   logic [1:0] mark_i;
   logic [1:0] rdy_o, tx_o, busy_o, done_o;

   int errs = 0;
   int checks = 0;

   // Model state: expected outputs and the pending frame per instance.
   logic [1:0] e_tx = 2'b11, e_busy = 2'b00, e_rdy = 2'b11, e_done = 2'b00;
   logic       fb [2][16];
   int         rem [2];
   int         idx [2];

   always #5 clk = ~clk;

   upc_tag_tx #(.BIT_CYCLES(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .tag_valid(v_i[0]), .tag_upc(upc_i[0]),
      .tag_mark(mark_i[0]), .tag_ready(rdy_o[0]), .tx(tx_o[0]),
      .busy(busy_o[0]), .frame_done(done_o[0]));

   upc_tag_tx #(.BIT_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .tag_valid(v_i[1]), .tag_upc(upc_i[1]),
      .tag_mark(mark_i[1]), .tag_ready(rdy_o[1]), .tx(tx_o[1]),
      .busy(busy_o[1]), .frame_done(done_o[1]));

   function automatic int bc(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Build the bit list of a frame from the tag currently on the inputs.
   task automatic load(input int i);
      logic [5:0] d;
      logic       p;
      int         nd;
      d    = '0;
      d[0] = mark_i[i];
      d[1] = upc_i[i][0];
      d[2] = upc_i[i][1];
      d[3] = upc_i[i][2];
      nd   = 4;
`ifdef UPC_TX_CLASS_EN
      d[4] = upc_i[i][1] | (upc_i[i][2] & upc_i[i][0]);
      d[5] = (upc_i[i][2] | ~upc_i[i][0]) & ~upc_i[i][1] & ~mark_i[i];
      nd   = 6;
`endif
      p = 1'b0;
      fb[i][0] = 1'b0;
      for (int j = 0; j < nd; j++) begin
         fb[i][1+j] = d[j];
         p = p ^ d[j];
      end
      fb[i][nd+1] = p;
      fb[i][nd+2] = 1'b1;
      rem[i] = (nd + 3) * bc(i);
      idx[i] = 0;
   endtask

   // Model: each edge consumes one cycle of the pending frame.
   initial begin
      rem[0] = 0; rem[1] = 0; idx[0] = 0; idx[1] = 0;
      forever begin
         @(posedge clk or negedge reset_n);
         for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
               rem[i] = 0; idx[i] = 0;
               e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_rdy[i] = 1'b1; e_done[i] = 1'b0;
            end else begin
               if (v_i[i] && e_rdy[i]) load(i);
               if (rem[i] > 0) begin
                  e_tx[i] = fb[i][idx[i] / bc(i)];
                  idx[i]++;
                  rem[i]--;
                  e_done[i] = 1'b0; e_busy[i] = 1'b1; e_rdy[i] = 1'b0;
               end else begin
                  e_done[i] = e_busy[i];
                  e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_rdy[i] = 1'b1;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_tx%0d", i),   tx_o[i],   e_tx[i]);
            chk($sformatf("m_busy%0d", i), busy_o[i], e_busy[i]);
            chk($sformatf("m_rdy%0d", i),  rdy_o[i],  e_rdy[i]);
            chk($sformatf("m_done%0d", i), done_o[i], e_done[i]);
         end
      end
   end

   // Called at the negedge of accept+1; returns at the negedge of accept+NB*bc+2.
   task automatic lit_frame(input int i, input logic [8:0] fr, input int b, input bit scr);
      int nbusy = 0;
      int dat = -1;
      for (int c = 0; c <= NB * b; c++) begin
         if (c < NB * b && c % b == 0)
            chk($sformatf("lit_bit%0d_i%0d", c / b, i), tx_o[i], fr[c / b]);
         if (busy_o[i]) nbusy++;
         if (done_o[i] && dat < 0) dat = c + 1;
         if (c == NB * b) chk("lit_gap_tx", tx_o[i], 1);
         if (scr) begin
            chk("lit_rdy_hold", rdy_o[i], (c == NB * b) ? 1 : 0);
            if (c < NB * b) begin
               upc_i[i]  = 3'($urandom);
               mark_i[i] = 1'($urandom);
            end else begin
               upc_i[i]  = 3'b111;
               mark_i[i] = 1'b1;
            end
         end
         @(negedge clk);
      end
      chk("lit_busy_len", nbusy, NB * b);
      chk("lit_done_at", dat, NB * b + 1);
   endtask

   initial begin
      int ndone;
      v_i = '0; mark_i = '0; upc_i[0] = '0; upc_i[1] = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Reset and idle.
      chk("rst_tx", tx_o[0], 1);
      chk("rst_rdy", rdy_o[0], 1);
      chk("rst_busy", busy_o[0], 0);
      chk("rst_done", done_o[0], 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("idle_tx", tx_o[0], 1);
         chk("idle_rdy", rdy_o[0], 1);
      end

      // Single tag 101 / mark 0.
      v_i[0] = 1'b1; upc_i[0] = 3'b101; mark_i[0] = 1'b0;
      @(negedge clk);
      v_i[0] = 1'b0;
      lit_frame(0, F_101, 4, 1'b0);

      // tag_valid held with changing data; next tag taken in the done cycle.
      v_i[0] = 1'b1; upc_i[0] = 3'b101; mark_i[0] = 1'b0;
      @(negedge clk);
      lit_frame(0, F_101, 4, 1'b1);
      v_i[0] = 1'b0;
      lit_frame(0, F_111, 4, 1'b0);

      // Back-to-back 010/1 then 000/0.
      v_i[0] = 1'b1; upc_i[0] = 3'b010; mark_i[0] = 1'b1;
      @(negedge clk);
      upc_i[0] = 3'b000; mark_i[0] = 1'b0;
      lit_frame(0, F_A, 4, 1'b0);
      v_i[0] = 1'b0;
      lit_frame(0, F_B, 4, 1'b0);

      // Reset during the d2 bit.
      v_i[0] = 1'b1; upc_i[0] = 3'b011; mark_i[0] = 1'b0;
      @(negedge clk);
      v_i[0] = 1'b0;
      repeat (13) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_tx", tx_o[0], 1);
      chk("arst_busy", busy_o[0], 0);
      chk("arst_rdy", rdy_o[0], 1);
      chk("arst_done", done_o[0], 0);
      #1 reset_n = 1'b1;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_o[0]) ndone++;
      end
      chk("arst_no_done", ndone, 0);
      v_i[0] = 1'b1; upc_i[0] = 3'b101; mark_i[0] = 1'b0;
      @(negedge clk);
      v_i[0] = 1'b0;
      lit_frame(0, F_101, 4, 1'b0);

      // BIT_CYCLES=1, tag 111 / mark 1.
      v_i[1] = 1'b1; upc_i[1] = 3'b111; mark_i[1] = 1'b1;
      @(negedge clk);
      v_i[1] = 1'b0;
      lit_frame(1, F_111, 1, 1'b0);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
